freq_div_monitor: RTL

- Downstream checker for the frequency-divider stage: takes the divided clock as a data input and samples it in the source clock domain.
- Produces one-cycle rise/fall strobes for logic that needs a clock enable instead of a derived clock.
- Measures period and high time in source-clock cycles and reports lock when the measured ratio matches the expected divide ratio.

---
 rtl/freq_div_monitor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/freq_div_monitor.sv
// Samples a divided clock as data in the clk domain, emits edge strobes,
// measures period/high time and tracks lock against the expected divide ratio.
//
// state  | meaning
// IDLE   | waiting for first clk_in rise; cnt held at 0
// ACQ    | measuring, counting consecutive good periods
// LOCKED | LOCK_CNT consecutive good periods seen
module freq_div_monitor #(
  parameter int CNT_W    = 16,
  parameter int EXP_DIV  = 4,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             clr,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic             timeout_pulse
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int LO_I = (EXP_DIV > TOL) ? (EXP_DIV - TOL) : 0;
  localparam logic [CNT_W-1:0] LO_LIM = CNT_W'(LO_I);
  localparam logic [CNT_W-1:0] HI_LIM = CNT_W'(EXP_DIV + TOL);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    LOCK_N = GW'(LOCK_CNT);

  logic s1, s2, s3;
  logic [1:0] prime;
  logic rise_det, fall_det;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [GW-1:0] good_cnt, good_nx, good_inc;
  logic good_per, err_nx, tmo_nx, seen_first;

  // Edge detection stays off until s2 and s3 both hold real samples, so
  // leaving reset with clk_in already high does not look like a rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      prime <= 2'd0;
    end else begin
      s1 <= clk_in;
      s2 <= s1;
      s3 <= s2;
      if (prime != 2'd3) prime <= prime + 2'd1;
    end
  end

  assign rise_det   = (prime == 2'd3) &  s2 & ~s3;
  assign fall_det   = (prime == 2'd3) & ~s2 &  s3;
  assign seen_first = (state != IDLE);
  assign good_per   = (period >= LO_LIM) && (period <= HI_LIM);
  assign good_inc   = good_cnt + GW'(1);
  assign locked     = (state == LOCKED);

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    cnt_nx   = cnt;
    err_nx   = 1'b0;
    tmo_nx   = 1'b0;
    if (rise_det)          cnt_nx = CNT_W'(1);
    else if (state == IDLE) cnt_nx = '0;
    else if (cnt != TMO)   cnt_nx = cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        if (rise_det) begin
          state_nx = ACQ;
          good_nx  = '0;
        end
      end
      ACQ: begin
        if (period_valid) begin
          if (good_per) begin
            good_nx = good_inc;
            if (good_inc == LOCK_N) state_nx = LOCKED;
          end else begin
            good_nx = '0;
            err_nx  = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (period_valid && !good_per) begin
          state_nx = ACQ;
          good_nx  = '0;
          err_nx   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A rise in the same cycle wins over the timeout.
    if (seen_first && !rise_det && cnt == TMO) begin
      state_nx = IDLE;
      good_nx  = '0;
      cnt_nx   = '0;
      err_nx   = 1'b0;
      tmo_nx   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      good_cnt      <= '0;
      period        <= '0;
      high_time     <= '0;
      rise_pulse    <= 1'b0;
      fall_pulse    <= 1'b0;
      period_valid  <= 1'b0;
      err_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
    end else if (clr) begin
      state         <= IDLE;
      cnt           <= '0;
      good_cnt      <= '0;
      period        <= '0;
      high_time     <= '0;
      rise_pulse    <= 1'b0;
      fall_pulse    <= 1'b0;
      period_valid  <= 1'b0;
      err_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      good_cnt      <= good_nx;
      rise_pulse    <= rise_det;
      fall_pulse    <= fall_det;
      period_valid  <= rise_det && seen_first;
      err_pulse     <= err_nx;
      timeout_pulse <= tmo_nx;
      if (rise_det && seen_first) period    <= cnt;
      if (fall_det && seen_first) high_time <= cnt;
    end
  end

endmodule
